servo_pwm_sweep: RTL and testbench
==================================

# servo_pwm_sweep

Servo actuator stage that consumes the one-cycle detect pulse from the upstream sequence-detector FSM and drives a hobby-servo PWM line. At rest the servo is held at the home pulse width. Each accepted trigger runs one sweep: ramp the pulse width up to the far position, hold it there, then ramp back to home. Pulse-width changes take effect only at PWM period boundaries, so the output never glitches.

## Interface
- PERIOD, 1000000: PWM period in clk cycles (20 ms at 50 MHz); legal range 2..2^CW.
- W_MIN, 50000: home pulse width in cycles; 1 ≤ W_MIN < W_MAX.
- W_MAX, 100000: far pulse width in cycles; W_MAX < PERIOD.
- STEP, 5000: width change per period while ramping; ≥ 1.
- HOLD, 25: number of full periods output at W_MAX; ≥ 1.
- CW, 20: width of the period counter and width registers.
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- trig  in  1  start request; one-cycle pulse from the detector.
- pwm  out  1  servo PWM, registered.
- busy  out  1  high from trigger acceptance until the sweep completes.
- done  out  1  one-cycle pulse when the sweep returns to home.
- width_q  out  CW  pulse width applied in the current period.

## Operation
- Period counter `cnt` counts 0..PERIOD-1 and wraps. A boundary is any cycle with cnt == PERIOD-1.
- At each clock edge, pwm <= (cnt < width_q). Result: pwm is high for exactly width_q cycles per period, lagging cnt by one cycle.
- width_q loads only on the boundary edge, taking the value computed for the new period. Between boundaries it is constant.
- Trigger capture:
  - trig sampled high while busy == 0 sets `pending` on that edge.
  - trig while busy == 1 is ignored; there is no queueing.
- States: IDLE, RAMP_UP, HOLD_ST, RAMP_DOWN. All transitions occur only on boundary edges.
- IDLE: width = W_MIN.
  - If pending == 1 at a boundary: clear pending, go to RAMP_UP, and apply the first step: width = min(W_MIN+STEP, W_MAX).
  - If that step already reaches W_MAX, go directly to HOLD_ST with hold_cnt = 1.
- RAMP_UP: at each boundary, width = min(width+STEP, W_MAX). When the result equals W_MAX, go to HOLD_ST with hold_cnt = 1.
- HOLD_ST: at each boundary:
  - If hold_cnt == HOLD, go to RAMP_DOWN and apply width = max(width−STEP, W_MIN).
  - Otherwise increment hold_cnt.
  - Net effect: exactly HOLD periods at W_MAX.
- RAMP_DOWN: at each boundary, width = max(width−STEP, W_MIN). When the result equals W_MIN, go to IDLE.
- Saturation compare is done at CW+1 bits, so no wrap-around is possible.
- busy = pending OR (state ≠ IDLE), registered.
- done pulses high for one cycle on the edge where RAMP_DOWN → IDLE.

## Timing
- Reset values: cnt=0, state=IDLE, pending=0, width_q=W_MIN, hold_cnt=0, pwm=0, busy=0, done=0.
- First edge after reset release: pwm=1. In idle, the block outputs continuous W_MIN pulses.
- Trigger to busy: 1 cycle.
- Trigger to first changed period: the next boundary, at most PERIOD cycles.
- trig on the boundary cycle itself: captured into pending, acted on at the following boundary, i.e. PERIOD cycles later.
- Sweep length in periods: ceil((W_MAX−W_MIN)/STEP) − 1 + HOLD + ceil((W_MAX−W_MIN)/STEP).
- busy falls on the same edge that done rises.
- A new trig is accepted in the cycle done is high.
- rst asserted mid-sweep: all registers return to reset values immediately. pwm drops to 0 asynchronously. No done pulse is generated.

## Test plan
All scenarios use PERIOD=20, W_MIN=4, W_MAX=10, STEP=4, HOLD=2, CW=5.
- Idle after reset: no trig for 3 periods → pwm high 4 cycles per 20-cycle period; busy=0; width_q=4.
- Single sweep, trig mid-period → successive period widths 8, 10, 10, 6, 4.
  - busy high from 1 cycle after trig until the 6→4 boundary.
  - done high exactly one cycle at that boundary.
  - Saturation is exercised: 8+4→10 and 6−4→4.
- Trig ignored: extra trig pulses during RAMP_UP and HOLD_ST → width sequence unchanged; exactly one done pulse.
- Trig on boundary cycle (cnt==19) while idle → width 8 appears one period later than a mid-period trig would produce; widths never change mid-period.
- Back-to-back: trig in the done cycle → second sweep 8, 10, 10, 6, 4 starts at the next boundary; busy low for only that one cycle.
- Reset mid-HOLD_ST: assert rst → pwm=0 and busy=0 immediately, width_q=4, no done pulse; after release, idle 4-cycle pulses resume.

Source files
------------

// File: rtl/servo_pwm_sweep.sv
// Servo PWM stage: holds the home width at rest and runs one up/hold/down sweep per accepted trigger.
// Width, state and hold count change only on period-boundary edges, so pwm never glitches mid-period.
module servo_pwm_sweep #(
  parameter int PERIOD = 1000000,
  parameter int W_MIN  = 50000,
  parameter int W_MAX  = 100000,
  parameter int STEP   = 5000,
  parameter int HOLD   = 25,
  parameter int CW     = 20
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          trig,
  output logic          pwm,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] width_q
);

  // A step larger than W_MAX saturates identically in both directions, so clamp it to keep sums in CW+1 bits.
  localparam int STEP_C = (STEP > W_MAX) ? W_MAX : STEP;
  localparam int HW     = $clog2(HOLD + 1);

  localparam logic [CW-1:0] LAST     = CW'(PERIOD - 1);
  localparam logic [CW-1:0] WMIN_C   = CW'(W_MIN);
  localparam logic [CW-1:0] WMAX_C   = CW'(W_MAX);
  localparam logic [CW:0]   STEP_X   = (CW+1)'(STEP_C);
  localparam logic [CW:0]   WMAX_X   = (CW+1)'(W_MAX);
  localparam logic [CW:0]   DN_FLOOR = (CW+1)'(W_MIN + STEP_C);
  localparam logic [HW-1:0] HOLD_C   = HW'(HOLD);

  typedef enum logic [1:0] {IDLE, RAMP_UP, HOLD_ST, RAMP_DOWN} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          pending;
  logic [HW-1:0] hold_cnt;
  logic          boundary;
  logic [CW:0]   up_sum;
  logic [CW-1:0] w_up;
  logic [CW-1:0] w_dn;

  assign boundary = (cnt == LAST);
  assign up_sum   = {1'b0, width_q} + STEP_X;
  assign w_up     = (up_sum >= WMAX_X) ? WMAX_C : up_sum[CW-1:0];
  assign w_dn     = ({1'b0, width_q} >= DN_FLOOR) ? (width_q - STEP_X[CW-1:0]) : WMIN_C;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      pwm <= 1'b0;
    end else begin
      cnt <= boundary ? '0 : cnt + 1'b1;
      pwm <= (cnt < width_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pending  <= 1'b0;
      width_q  <= WMIN_C;
      hold_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      // pending implies busy, so a capture never coincides with the IDLE boundary clearing it
      if (trig && !busy) begin
        pending <= 1'b1;
        busy    <= 1'b1;
      end
      if (boundary) begin
        case (state)
          IDLE: begin
            if (pending) begin
              pending <= 1'b0;
              width_q <= w_up;
              if (w_up == WMAX_C) begin
                state    <= HOLD_ST;
                hold_cnt <= HW'(1);
              end else begin
                state <= RAMP_UP;
              end
            end
          end
          RAMP_UP: begin
            width_q <= w_up;
            if (w_up == WMAX_C) begin
              state    <= HOLD_ST;
              hold_cnt <= HW'(1);
            end
          end
          HOLD_ST: begin
            if (hold_cnt == HOLD_C) begin
              state   <= RAMP_DOWN;
              width_q <= w_dn;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
          RAMP_DOWN: begin
            width_q <= w_dn;
            if (w_dn == WMIN_C) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_servo_pwm_sweep.sv
// Bench for servo_pwm_sweep: per-cycle comparison against a sweep-list model,
// plus directed width sequences, done counts and async reset checks.
module tb_servo_pwm_sweep;
  localparam int PERIOD = 20;
  localparam int W_MIN  = 4;
  localparam int W_MAX  = 10;
  localparam int STEP   = 4;
  localparam int HOLD   = 2;
  localparam int CW     = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          trig = 1'b0;
  logic          pwm, busy, done;
  logic [CW-1:0] width_q;

  int n_cmp = 0;
  int n_bad = 0;
  int ndone = 0;

  // model: period phase, applied width, pending flag, and the list of widths still to apply
  int m_cnt, m_width, m_pending, m_pwm, m_busy, m_done;
  int m_seq[$];

  servo_pwm_sweep #(
    .PERIOD(PERIOD), .W_MIN(W_MIN), .W_MAX(W_MAX),
    .STEP(STEP), .HOLD(HOLD), .CW(CW)
  ) dut (
    .clk(clk), .rst(rst), .trig(trig),
    .pwm(pwm), .busy(busy), .done(done), .width_q(width_q)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_width = W_MIN; m_pending = 0;
    m_pwm = 0; m_busy = 0; m_done = 0;
    m_seq.delete();
  endtask

  task automatic build_sweep();
    int w;
    w = W_MIN;
    do begin
      w = (w + STEP > W_MAX) ? W_MAX : w + STEP;
      m_seq.push_back(w);
    end while (w != W_MAX);
    repeat (HOLD - 1) m_seq.push_back(W_MAX);
    do begin
      w = (w - STEP < W_MIN) ? W_MIN : w - STEP;
      m_seq.push_back(w);
    end while (w != W_MIN);
  endtask

  task automatic model_step(input logic t);
    bit bnd;
    bnd = (m_cnt == PERIOD - 1);
    m_pwm  = (m_cnt < m_width) ? 1 : 0;
    m_done = 0;
    if (bnd) begin
      if (m_seq.size() == 0 && m_pending != 0) begin
        m_pending = 0;
        build_sweep();
      end
      if (m_seq.size() != 0) begin
        m_width = m_seq.pop_front();
        if (m_seq.size() == 0) m_done = 1;
      end
    end
    if (t && m_busy == 0) m_pending = 1;
    m_busy = (m_pending != 0 || m_seq.size() != 0) ? 1 : 0;
    m_cnt  = bnd ? 0 : m_cnt + 1;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else     model_step(trig);
    end
  end

  initial forever begin
    @(negedge clk);
    check("pwm", pwm, m_pwm);
    check("busy", busy, m_busy);
    check("done", done, m_done);
    check("width_q", width_q, m_width);
    if (done === 1'b1) ndone++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish, got timeout, expected completion");
    $fatal(1);
  end

  task automatic pulse();
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
  endtask

  task automatic wait_phase(input int ph);
    do @(negedge clk); while (m_cnt != ph);
  endtask

  // samples width_q once per period at phase 5, from the next phase-5 cycle on
  task automatic expect_widths(input string tag, input int exp[$]);
    foreach (exp[i]) begin
      wait_phase(5);
      check($sformatf("%s_w%0d", tag, i), width_q, exp[i]);
    end
  endtask

  task automatic sweep(input string tag, input int phase, input bit extra);
    int exp[$];
    int d0;
    exp = {8, 10, 10, 6, 4};
    if (phase == PERIOD - 1) exp.push_front(W_MIN);
    wait_phase(phase);
    d0 = ndone;
    pulse();
    foreach (exp[i]) begin
      wait_phase(5);
      check($sformatf("%s_w%0d", tag, i), width_q, exp[i]);
      if (extra && i < 2) pulse();
    end
    check({tag, "_ndone"}, ndone - d0, 1);
  endtask

  task automatic idle_window(input string tag);
    int hi;
    hi = 0;
    repeat (3 * PERIOD) begin
      if (pwm === 1'b1) hi++;
      @(negedge clk);
    end
    check({tag, "_pwm_hi"}, hi, 3 * W_MIN);
    check({tag, "_width"}, width_q, W_MIN);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int q[$];
    int k;
    int d0;
    repeat (3) @(negedge clk);
    check("reset_pwm", pwm, 0);
    check("reset_width", width_q, W_MIN);
    rst = 1'b0;
    @(negedge clk);
    check("first_pwm", pwm, 1);
    idle_window("idle");

    sweep("single", 7, 1'b0);
    sweep("ignore", 11, 1'b1);
    sweep("bnd", PERIOD - 1, 1'b0);

    // back-to-back: retrigger in the done cycle
    wait_phase(7);
    pulse();
    k = 0;
    while (done !== 1'b1 && k < 10 * PERIOD) begin
      @(negedge clk);
      k++;
    end
    check("b2b_done_seen", done, 1);
    check("b2b_busy_lo", busy, 0);
    pulse();
    check("b2b_busy_hi", busy, 1);
    q = {4, 8, 10, 10, 6, 4};
    expect_widths("b2b", q);

    // reset during the first HOLD period
    wait_phase(7);
    pulse();
    q = {8, 10};
    expect_widths("pre_rst", q);
    d0 = ndone;
    #2 rst = 1'b1;
    #1;
    check("rst_pwm", pwm, 0);
    check("rst_busy", busy, 0);
    check("rst_width", width_q, W_MIN);
    check("rst_done", done, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    idle_window("post_rst");
    check("rst_no_done", ndone - d0, 0);

    repeat (4) sweep("rand", $urandom_range(6, PERIOD - 2), 1'(($urandom_range(0, 1))));

    repeat (3000) begin
      trig = ($urandom_range(0, 39) == 0);
      @(negedge clk);
    end
    trig = 1'b0;
    repeat (10 * PERIOD) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
